// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants, FSM state type and small helpers.
package fetch_unit_pkg;

    localparam int          WORD_WIDTH  = 32;
    localparam logic [31:0] PCBASE      = 32'h0000_0000;

    localparam logic [8:0]  EXC_NONE    = 9'h000;
    localparam logic [8:0]  EXC_ADEL_IF = 9'h002;

    localparam logic [31:0] INSTR_NOP   = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    // A fetch address is word-aligned only when its two low bits are zero.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_rvalid;
    logic [WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, otherwise bubble.
// A bubble clears valid and the exception code; instr/pc are left as they were.
module if_id_reg
    import fetch_unit_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             stall_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] instr_i,
    input  logic [WIDTH-1:0] pc_i,
    input  logic [8:0]       exc_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] instr_o,
    output logic [WIDTH-1:0] pc_o,
    output logic [8:0]       exc_o
);

    logic             valid_q;
    logic [WIDTH-1:0] instr_q;
    logic [WIDTH-1:0] pc_q;
    logic [8:0]       exc_q;

    // Prioritised update of the pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
            exc_q   <= EXC_NONE;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            exc_q   <= EXC_NONE;
        end else if (stall_i) begin
            valid_q <= valid_q;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
            exc_q   <= exc_i;
        end else begin
            valid_q <= 1'b0;
            exc_q   <= EXC_NONE;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign exc_o   = exc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues the imem request for pc, parks a completed
// fetch while decode stalls, and drains a flushed in-flight transaction.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   FETCH   | requesting pc (or completing a misaligned pc immediately)
//   HOLD    | completed fetch parked in the buffer, decode stalled
//   DISCARD | flushed request still outstanding; its response is dropped
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   pc,
    input  logic               stall_d,
    input  logic               flush,
    fetch_unit_if.master       imem,
    output logic               installF,
    output logic               valid_d,
    output logic [WIDTH-1:0]   instr_d,
    output logic [WIDTH-1:0]   pc_d,
    output logic [8:0]         exception_d
);

    fetch_state_e     state_q;
    logic [WIDTH-1:0] buf_instr_q;
    logic [WIDTH-1:0] buf_pc_q;
    logic [8:0]       buf_exc_q;
    logic [WIDTH-1:0] disc_addr_q;

    logic             misal;
    logic             done;
    logic             load;
    logic [WIDTH-1:0] live_instr;
    logic [8:0]       live_exc;
    logic [WIDTH-1:0] ld_instr;
    logic [WIDTH-1:0] ld_pc;
    logic [8:0]       ld_exc;

    assign misal = is_misaligned(pc[1:0]);
    assign done  = (state_q == ST_FETCH) && (imem.imem_rvalid || misal);
    assign load  = !flush && !stall_d && (done || (state_q == ST_HOLD));
    assign installF = !(load || flush);

    // A misaligned pc never reaches memory; it yields a NOP tagged with the fetch exception.
    assign live_instr = misal ? WIDTH'(INSTR_NOP) : imem.imem_rdata;
    assign live_exc   = misal ? EXC_ADEL_IF : EXC_NONE;

    assign ld_instr = (state_q == ST_HOLD) ? buf_instr_q : live_instr;
    assign ld_pc    = (state_q == ST_HOLD) ? buf_pc_q    : pc;
    assign ld_exc   = (state_q == ST_HOLD) ? buf_exc_q   : live_exc;

    // Request drive: DISCARD keeps the flushed address on the bus until it answers.
    always_comb begin
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc;
        unique case (state_q)
            ST_FETCH: begin
                imem.imem_req  = !misal;
                imem.imem_addr = pc;
            end
            ST_HOLD: begin
                imem.imem_req  = 1'b0;
                imem.imem_addr = pc;
            end
            ST_DISCARD: begin
                imem.imem_req  = 1'b1;
                imem.imem_addr = disc_addr_q;
            end
            default: begin
                imem.imem_req  = 1'b0;
                imem.imem_addr = pc;
            end
        endcase
    end

    // Fetch sequencing, park buffer and discard address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
            buf_exc_q   <= EXC_NONE;
            disc_addr_q <= '0;
        end else begin
            unique case (state_q)
                ST_FETCH: begin
                    if (done && stall_d && !flush) begin
                        state_q     <= ST_HOLD;
                        buf_instr_q <= live_instr;
                        buf_pc_q    <= pc;
                        buf_exc_q   <= live_exc;
                    end else if (!misal && !imem.imem_rvalid && flush) begin
                        state_q     <= ST_DISCARD;
                        disc_addr_q <= pc;
                    end
                end
                ST_HOLD: begin
                    if (flush || load) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_DISCARD: begin
                    if (imem.imem_rvalid) begin
                        state_q <= ST_FETCH;
                    end
                end
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    if_id_reg #(
        .WIDTH(WIDTH)
    ) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .stall_i (stall_d),
        .load_i  (load),
        .instr_i (ld_instr),
        .pc_i    (ld_pc),
        .exc_i   (ld_exc),
        .valid_o (valid_d),
        .instr_o (instr_d),
        .pc_o    (pc_d),
        .exc_o   (exception_d)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a
// transaction-level model (parked word / dropped request / IF/ID contents).
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] TB_PCBASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        stall_d;
    logic        flush;
    logic        installF;
    logic        valid_d;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [8:0]  exception_d;

    int vecs = 0;
    int errs = 0;

    fetch_unit_if #(.WIDTH(32)) imem ();

    fetch_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .stall_d     (stall_d),
        .flush       (flush),
        .imem        (imem),
        .installF    (installF),
        .valid_d     (valid_d),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .exception_d (exception_d)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_5A5A;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] p, input logic st, input logic fl,
                         input logic rv, input logic [31:0] rd);
        pc = p; stall_d = st; flush = fl;
        imem.imem_rvalid = rv; imem.imem_rdata = rd;
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(32'h0000_0abc, 1'b1, 1'b1, 1'b1, 32'hffff_ffff);
        tick(); tick();
        rst = 1'b0;
        drive(TB_PCBASE, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs++; if (valid_d !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b exp=0", valid_d); end
        vecs++; if (instr_d !== 32'h0) begin errs++; $display("FAIL reset_instr got=%h exp=0", instr_d); end
        vecs++; if (pc_d !== 32'h0) begin errs++; $display("FAIL reset_pc got=%h exp=0", pc_d); end
        vecs++; if (exception_d !== 9'h0) begin errs++; $display("FAIL reset_exc got=%h exp=0", exception_d); end
        vecs++; if (imem.imem_req !== 1'b1) begin errs++; $display("FAIL reset_req got=%b exp=1", imem.imem_req); end
        vecs++; if (imem.imem_addr !== TB_PCBASE) begin errs++; $display("FAIL reset_addr got=%h exp=%h", imem.imem_addr, TB_PCBASE); end
        vecs++; if (installF !== 1'b1) begin errs++; $display("FAIL reset_installF got=%b exp=1", installF); end
        tick();
    endtask

    task automatic test_zero_wait();
        for (int i = 0; i < 5; i++) begin
            drive(32'(4 * i), 1'b0, 1'b0, 1'b1, word_of(32'(4 * i)));
            vecs++; if (installF !== 1'b0) begin errs++; $display("FAIL zw_installF[%0d] got=%b exp=0", i, installF); end
            vecs++; if (imem.imem_addr !== 32'(4 * i)) begin errs++; $display("FAIL zw_addr[%0d] got=%h exp=%h", i, imem.imem_addr, 4 * i); end
            if (i > 0) begin
                vecs++; if (valid_d !== 1'b1) begin errs++; $display("FAIL zw_valid[%0d] got=%b exp=1", i, valid_d); end
                vecs++; if (pc_d !== 32'(4 * (i - 1))) begin errs++; $display("FAIL zw_pc[%0d] got=%h exp=%h", i, pc_d, 4 * (i - 1)); end
                vecs++; if (instr_d !== word_of(32'(4 * (i - 1)))) begin errs++; $display("FAIL zw_instr[%0d] got=%h exp=%h", i, instr_d, word_of(32'(4 * (i - 1)))); end
            end
            tick();
        end
    endtask

    task automatic test_latency();
        for (int i = 0; i < 3; i++) begin
            drive(32'h100, 1'b0, 1'b0, (i == 2), (i == 2) ? 32'hCAFE_0100 : 32'h0);
            vecs++; if (installF !== (i != 2)) begin errs++; $display("FAIL lat_installF[%0d] got=%b exp=%b", i, installF, (i != 2)); end
            vecs++; if (imem.imem_addr !== 32'h100) begin errs++; $display("FAIL lat_addr[%0d] got=%h exp=100", i, imem.imem_addr); end
            if (i > 0) begin
                vecs++; if (valid_d !== 1'b0) begin errs++; $display("FAIL lat_bubble[%0d] got=%b exp=0", i, valid_d); end
            end
            tick();
        end
        vecs++; if (valid_d !== 1'b1 || instr_d !== 32'hCAFE_0100 || pc_d !== 32'h100) begin
            errs++; $display("FAIL lat_word got=%b/%h/%h exp=1/cafe0100/00000100", valid_d, instr_d, pc_d);
        end
    endtask

    task automatic test_stall_hold();
        drive(32'h300, 1'b1, 1'b0, 1'b1, 32'h1234_5678);
        vecs++; if (installF !== 1'b1) begin errs++; $display("FAIL st_installF0 got=%b exp=1", installF); end
        tick();
        drive(32'h300, 1'b1, 1'b0, 1'b0, 32'h0);
        vecs++; if (imem.imem_req !== 1'b0) begin errs++; $display("FAIL st_hold_req got=%b exp=0", imem.imem_req); end
        vecs++; if (installF !== 1'b1) begin errs++; $display("FAIL st_installF1 got=%b exp=1", installF); end
        tick();
        drive(32'h300, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs++; if (imem.imem_req !== 1'b0) begin errs++; $display("FAIL st_hold_req2 got=%b exp=0", imem.imem_req); end
        vecs++; if (installF !== 1'b0) begin errs++; $display("FAIL st_release got=%b exp=0", installF); end
        tick();
        vecs++; if (valid_d !== 1'b1 || instr_d !== 32'h1234_5678 || pc_d !== 32'h300) begin
            errs++; $display("FAIL st_word got=%b/%h/%h exp=1/12345678/00000300", valid_d, instr_d, pc_d);
        end
        drive(32'h304, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs++; if (imem.imem_req !== 1'b1) begin errs++; $display("FAIL st_refetch_req got=%b exp=1", imem.imem_req); end
        tick();
        vecs++; if (valid_d !== 1'b0) begin errs++; $display("FAIL st_single_load got=%b exp=0", valid_d); end
    endtask

    task automatic test_misaligned();
        drive(32'h102, 1'b0, 1'b0, 1'b0, 32'h5555_5555);
        vecs++; if (imem.imem_req !== 1'b0) begin errs++; $display("FAIL mis_req got=%b exp=0", imem.imem_req); end
        vecs++; if (installF !== 1'b0) begin errs++; $display("FAIL mis_installF got=%b exp=0", installF); end
        tick();
        vecs++; if (valid_d !== 1'b1 || instr_d !== 32'h0 || exception_d !== 9'h002 || pc_d !== 32'h102) begin
            errs++; $display("FAIL mis_word got=%b/%h/%h/%h exp=1/0/002/102", valid_d, instr_d, exception_d, pc_d);
        end
    endtask

    task automatic test_flush_inflight();
        drive(32'h200, 1'b0, 1'b1, 1'b0, 32'h0);
        vecs++; if (installF !== 1'b0) begin errs++; $display("FAIL fl_installF got=%b exp=0", installF); end
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(32'h400, 1'b0, 1'b0, (i == 1), 32'hDEAD_BEEF);
            vecs++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h200) begin
                errs++; $display("FAIL fl_disc_bus[%0d] got=%b/%h exp=1/00000200", i, imem.imem_req, imem.imem_addr);
            end
            vecs++; if (installF !== 1'b1) begin errs++; $display("FAIL fl_disc_installF[%0d] got=%b exp=1", i, installF); end
            vecs++; if (valid_d !== 1'b0) begin errs++; $display("FAIL fl_disc_valid[%0d] got=%b exp=0", i, valid_d); end
            tick();
        end
        drive(32'h400, 1'b0, 1'b0, 1'b1, word_of(32'h400));
        vecs++; if (imem.imem_addr !== 32'h400) begin errs++; $display("FAIL fl_new_addr got=%h exp=400", imem.imem_addr); end
        vecs++; if (valid_d !== 1'b0) begin errs++; $display("FAIL fl_dropped got=%b exp=0", valid_d); end
        tick();
        vecs++; if (valid_d !== 1'b1 || pc_d !== 32'h400 || instr_d !== word_of(32'h400)) begin
            errs++; $display("FAIL fl_new_word got=%b/%h/%h exp=1/00000400/%h", valid_d, pc_d, instr_d, word_of(32'h400));
        end
    endtask

    task automatic test_reset_in_hold();
        drive(32'h500, 1'b1, 1'b0, 1'b1, 32'h0BAD_0500);
        tick();
        rst = 1'b1;
        drive(32'h500, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        rst = 1'b0;
        drive(TB_PCBASE, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs++; if (valid_d !== 1'b0) begin errs++; $display("FAIL rh_valid got=%b exp=0", valid_d); end
        vecs++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== TB_PCBASE) begin
            errs++; $display("FAIL rh_bus got=%b/%h exp=1/%h", imem.imem_req, imem.imem_addr, TB_PCBASE);
        end
        tick();
    endtask

    task automatic test_random(input int ncyc);
        bit          parked, dropping, busy;
        logic [31:0] drop_addr, pk_i, pk_p, e_i, e_p, cur_pc, tgt, maddr, w_i;
        logic [8:0]  pk_e, e_e, w_e;
        bit          e_v, mis, exp_req, rv, avail, deliver, exp_inst;
        logic [31:0] exp_addr;
        int          cnt;
        rst = 1'b1;
        drive(TB_PCBASE, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(); tick();
        rst = 1'b0;
        parked = 0; dropping = 0; busy = 0; cnt = 0; maddr = '0; drop_addr = '0;
        pk_i = '0; pk_p = '0; pk_e = '0;
        e_v = 0; e_i = '0; e_p = '0; e_e = '0;
        cur_pc = TB_PCBASE;
        for (int c = 0; c < ncyc; c++) begin
            pc = cur_pc;
            stall_d = ($urandom_range(0, 3) == 0);
            flush   = ($urandom_range(0, 6) == 0);
            tgt = ($urandom & 32'h0000_0ffc) | (($urandom_range(0, 7) == 0) ? 32'h2 : 32'h0);
            #1;
            mis      = (cur_pc[1:0] != 2'b00);
            exp_req  = dropping ? 1'b1 : (parked ? 1'b0 : !mis);
            exp_addr = dropping ? drop_addr : cur_pc;
            rv = 1'b0;
            if (imem.imem_req) begin
                if (!busy) begin
                    cnt   = $urandom_range(0, 3);
                    maddr = imem.imem_addr;
                end else begin
                    vecs++; if (imem.imem_addr !== maddr) begin errs++; $display("FAIL rnd_addr_stable[%0d] got=%h exp=%h", c, imem.imem_addr, maddr); end
                end
                rv = (cnt == 0);
            end
            imem.imem_rvalid = rv;
            imem.imem_rdata  = rv ? word_of(imem.imem_addr) : $urandom;
            #1;
            w_i = mis ? 32'h0 : imem.imem_rdata;
            w_e = mis ? 9'h002 : 9'h000;
            avail    = parked || (!dropping && (mis || rv));
            deliver  = avail && !stall_d && !flush;
            exp_inst = !(deliver || flush);
            vecs++; if (imem.imem_req !== exp_req) begin errs++; $display("FAIL rnd_req[%0d] got=%b exp=%b", c, imem.imem_req, exp_req); end
            if (exp_req) begin
                vecs++; if (imem.imem_addr !== exp_addr) begin errs++; $display("FAIL rnd_addr[%0d] got=%h exp=%h", c, imem.imem_addr, exp_addr); end
            end
            vecs++; if (installF !== exp_inst) begin errs++; $display("FAIL rnd_installF[%0d] got=%b exp=%b", c, installF, exp_inst); end
            vecs++; if (valid_d !== e_v || exception_d !== e_e) begin
                errs++; $display("FAIL rnd_ifid_ctl[%0d] got=%b/%h exp=%b/%h", c, valid_d, exception_d, e_v, e_e);
            end
            if (e_v) begin
                vecs++; if (instr_d !== e_i || pc_d !== e_p) begin
                    errs++; $display("FAIL rnd_ifid_data[%0d] got=%h/%h exp=%h/%h", c, instr_d, pc_d, e_i, e_p);
                end
            end
            if (flush) begin
                e_v = 0; e_e = 9'h000;
            end else if (!stall_d) begin
                if (deliver) begin
                    e_v = 1;
                    e_i = parked ? pk_i : w_i;
                    e_p = parked ? pk_p : cur_pc;
                    e_e = parked ? pk_e : w_e;
                end else begin
                    e_v = 0; e_e = 9'h000;
                end
            end
            if (dropping) begin
                if (rv) dropping = 0;
            end else if (parked) begin
                if (flush || deliver) parked = 0;
            end else if (avail && stall_d && !flush) begin
                parked = 1; pk_i = w_i; pk_p = cur_pc; pk_e = w_e;
            end else if (!mis && !rv && flush) begin
                dropping = 1; drop_addr = cur_pc;
            end
            if (imem.imem_req) begin
                if (rv) busy = 0;
                else begin busy = 1; cnt = cnt - 1; end
            end
            cur_pc = flush ? tgt : (exp_inst ? cur_pc : cur_pc + 32'd4);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; pc = '0; stall_d = 1'b0; flush = 1'b0;
        imem.imem_rvalid = 1'b0; imem.imem_rdata = '0;
        test_reset();
        test_zero_wait();
        test_latency();
        test_stall_hold();
        test_misaligned();
        test_flush_inflight();
        test_reset_in_hold();
        test_random(3000);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
